// File: rtl/fifo_word_packer_pkg.sv
// Shared types for the fifo word packer: FSM states, lane-count type and keep-mask helper.
package fifo_pack_pkg;
    localparam int MAX_PACK = 16;

    typedef enum logic [1:0] {FILL, DRAIN, EMIT} pack_state_e;

    // Sized for the largest legal PACK so one type serves every instance.
    typedef logic [$clog2(MAX_PACK+1)-1:0] lane_cnt_t;

    function automatic logic [MAX_PACK-1:0] keep_mask(input lane_cnt_t n);
        logic [MAX_PACK:0] w_one;
        logic [MAX_PACK:0] w_mask;
        w_one  = {{MAX_PACK{1'b0}}, 1'b1};
        w_mask = (w_one << n) - w_one;
        return w_mask[MAX_PACK-1:0];
    endfunction
endpackage

// File: rtl/fifo_word_packer_timer.sv
// Idle counter for the packer: pulses o_timeout after TIMEOUT_CYC consecutive run cycles.
module fifo_pack_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_run,
    input  logic i_clear,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_idle;

    assign o_timeout = i_run && !i_clear && (r_idle == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle <= '0;
        end else if (i_clear || o_timeout) begin
            r_idle <= '0;
        end else if (i_run) begin
            r_idle <= r_idle + CW'(1);
        end
    end
endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive FIFO entries into one wide valid/ready word; flush emits partials.
// Build with FIFO_PACK_TIMEOUT_EN defined to add an idle auto-flush after TIMEOUT_CYC cycles.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int fifo_width  = 8,
    parameter int PACK        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [fifo_width-1:0]      fifo_data_out,
    input  logic                       fifo_empty,
    output logic                       fifo_read,
    input  logic                       flush,
    output logic [fifo_width*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int LW = fifo_width * PACK;

    pack_state_e         r_state;
    lane_cnt_t           r_cnt;
    logic                r_pend;
    logic                r_flush_pend;
    logic [LW-1:0]       r_lanes;

    logic [LW-1:0]       w_assembled;
    lane_cnt_t           w_inflight;
    logic [MAX_PACK-1:0] w_keep;
    logic                w_full;
    logic                w_residue;
    logic                w_flush;
    logic                w_timeout;

    // Bytes already landed plus the one in flight must never exceed a word.
    assign w_inflight = r_cnt + lane_cnt_t'(r_pend);
    assign fifo_read  = rstn && (r_state == FILL) && !fifo_empty && !r_flush_pend
                        && (w_inflight < lane_cnt_t'(PACK));

    assign w_full    = r_pend && (r_cnt == lane_cnt_t'(PACK - 1));
    assign w_residue = (r_cnt != '0) || r_pend;
    assign w_keep    = keep_mask(r_cnt);
    assign w_flush   = flush || w_timeout;

    always_comb begin
        w_assembled = r_lanes;
        if (r_pend && (r_cnt < lane_cnt_t'(PACK))) begin
            w_assembled[r_cnt*fifo_width +: fifo_width] = fifo_data_out;
        end
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    logic w_timer_run;
    logic w_timer_clear;

    assign w_timer_run   = (r_state == FILL) && (r_cnt != '0) && !r_pend;
    assign w_timer_clear = r_pend || (r_state != FILL);

    fifo_pack_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .i_run     (w_timer_run),
        .i_clear   (w_timer_clear),
        .o_timeout (w_timeout)
    );
`else
    // Without the idle timer TIMEOUT_CYC has no effect; this stays constant low.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= FILL;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_lanes      <= '0;
            out_data     <= '0;
            out_keep     <= '0;
            out_valid    <= 1'b0;
        end else begin
            r_pend <= fifo_read;
            if (r_pend) begin
                r_lanes <= w_assembled;
                r_cnt   <= r_cnt + lane_cnt_t'(1);
            end
            case (r_state)
                FILL: begin
                    if (w_full) begin
                        out_data  <= w_assembled;
                        out_keep  <= '1;
                        out_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_lanes   <= '0;
                        r_state   <= EMIT;
                    end else if (w_flush && w_residue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Lanes above r_cnt are already zero, so r_lanes is the padded word.
                    if (!r_pend) begin
                        out_data  <= r_lanes;
                        out_keep  <= w_keep[PACK-1:0];
                        out_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_lanes   <= '0;
                        r_state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        r_flush_pend <= 1'b0;
                        r_state      <= ((r_flush_pend || w_flush) && w_residue) ? DRAIN : FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: FIFO model, byte-stream grouping reference, scoreboard.
module tb_fifo_word_packer;
  localparam int W  = 8;
  localparam int P  = 4;
  localparam int TO = 64;
  localparam int EW = W*P + P;

  logic           clk;
  logic           rstn;
  logic [W-1:0]   fifo_data_out;
  logic           fifo_empty = 1'b1;
  logic           fifo_read;
  logic           flush;
  logic [W*P-1:0] out_data;
  logic [P-1:0]   out_keep;
  logic           out_valid;
  logic           out_ready;

  logic [W-1:0]   fifo_q[$];
  logic [W-1:0]   acc[$];
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  last_word;
  int             n_checks;
  int             n_pass;
  int             n_fail;
  int             pop_count;
  int             valid_cycles;

  fifo_word_packer #(
    .fifo_width  (W),
    .PACK        (P),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .flush         (flush),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // reference: group popped bytes into words, flush closes a non-empty group
  task automatic model_emit();
    logic [W*P-1:0] d;
    d = '0;
    foreach (acc[i]) d[i*W +: W] = acc[i];
    exp_q.push_back({P'((1 << acc.size()) - 1), d});
    acc.delete();
  endtask

  // FIFO with one-cycle read latency, plus the reference model
  always @(posedge clk) begin
    logic [W-1:0] b;
    bit           have_b;
    have_b = 1'b0;
    b      = '0;
    if (!rstn) begin
      acc.delete();
    end else begin
      if (fifo_read) begin
        check("fifo_underflow", (fifo_q.size() == 0), 0);
        if (fifo_q.size() != 0) begin
          b             = fifo_q.pop_front();
          have_b        = 1'b1;
          fifo_data_out <= b;
          pop_count++;
        end
      end
      if (flush && acc.size() != 0) begin
        if (have_b) acc.push_back(b);
        model_emit();
      end else if (have_b) begin
        acc.push_back(b);
        if (acc.size() == P) model_emit();
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // scoreboard: every valid cycle must show the head of the expected queue
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      valid_cycles++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", exp_q.size(), 1);
      end else begin
        check("out_word", {out_keep, out_data}, exp_q[0]);
        if (out_ready) begin
          last_word = {out_keep, out_data};
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int target);
    for (int i = 0; i < 200 && pop_count < target; i++) step();
    check(tag, pop_count, target);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && acc.size() == 0 && fifo_q.size() == 0 && !out_valid) break;
      step();
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int v0;
    n_checks = 0; n_pass = 0; n_fail = 0; pop_count = 0; valid_cycles = 0;
    last_word = '0;
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_fifo_read", fifo_read, 0);
    rstn = 1'b1;
    step();

    // full word
    p0 = pop_count; v0 = valid_cycles;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    wait_drain("t1_drain", 100);
    check("t1_pops", pop_count - p0, 4);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_word", last_word, {4'hF, 32'h44332211});

    // backpressure
    p0 = pop_count;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    repeat (20) step();
    check("t2_pops_stalled", pop_count - p0, 4);
    check("t2_fifo_read", fifo_read, 0);
    check("t2_valid", out_valid, 1);
    check("t2_data_held", out_data, 32'h04030201);
    out_ready = 1'b1;
    wait_drain("t2_drain", 100);
    check("t2_word2", last_word, {4'hF, 32'h08070605});
    check("t2_pops", pop_count - p0, 8);

    // flush partial, then flush with nothing accumulated
    p0 = pop_count;
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
    wait_pops("t3_pops", p0 + 2);
    step(); step();
    pulse_flush();
    wait_drain("t3_drain", 100);
    check("t3_word", last_word, {4'h3, 32'h0000BBAA});
    v0 = valid_cycles;
    pulse_flush();
    repeat (10) step();
    check("t3_empty_flush", valid_cycles - v0, 0);

    // flush with the third byte still in flight
    p0 = pop_count;
    fifo_q.push_back(8'h31); fifo_q.push_back(8'h32); fifo_q.push_back(8'h33);
    wait_pops("t4_pops", p0 + 3);
    pulse_flush();
    wait_drain("t4_drain", 100);
    check("t4_word", last_word, {4'h7, 32'h00333231});

    // empty FIFO
    p0 = pop_count; v0 = valid_cycles;
    repeat (50) step();
    check("t5_pops", pop_count - p0, 0);
    check("t5_valid", valid_cycles - v0, 0);

    // reset mid-fill
    p0 = pop_count;
    fifo_q.push_back(8'h61); fifo_q.push_back(8'h62);
    wait_pops("t6_pops", p0 + 2);
    step(); step();
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_keep", out_keep, 0);
    check("t6_rst_read", fifo_read, 0);
    fifo_q.delete(); exp_q.delete();
    step(); step();
    rstn = 1'b1;
    step();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h55 + i));
    wait_drain("t6_drain", 100);
    check("t6_word", last_word, {4'hF, 32'h58575655});

`ifdef FIFO_PACK_TIMEOUT_EN
    // idle timeout closes a single-byte word
    p0 = pop_count;
    fifo_q.push_back(8'h77);
    wait_pops("t7_pops", p0 + 1);
    model_emit();
    wait_drain("t7_drain", TO + 40);
    check("t7_word", last_word, {4'h1, 32'h00000077});
`endif

    // randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && fifo_q.size() != 0; i++) step();
    repeat (3) step();
    pulse_flush();
    wait_drain("rand_drain", 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
